// File: rtl/wb_port_arbiter_pkg.sv
// Shared sizing, source indices and buffer-entry type for the writeback port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned NUM_SRC  = 3;
    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned ONEHOT_W = 32;

    localparam int unsigned SRC_ALU  = 0;
    localparam int unsigned SRC_LOAD = 1;
    localparam int unsigned SRC_MDIV = 2;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_rd_decode.sv
// Register-address to 32-bit one-hot decoder with enable.
module wb_rd_decode #(
    parameter int unsigned AW = 5
) (
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   onehot_o
);

    assign onehot_o = en_i ? (32'(1) << addr_i) : 32'(0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter merging per-source writeback buffers onto one register-file write port.
module wb_port_arbiter #(
    parameter int unsigned NUM_SRC = wb_port_arbiter_pkg::NUM_SRC,
    parameter int unsigned DW      = wb_port_arbiter_pkg::DW,
    parameter int unsigned AW      = wb_port_arbiter_pkg::AW
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [NUM_SRC*AW-1:0] src_rd,
    input  logic [NUM_SRC*DW-1:0] src_data,
    output logic [NUM_SRC-1:0]    src_ready,
    output logic                  wb_we,
    output logic [AW-1:0]         wb_rd,
    output logic [DW-1:0]         wb_data,
    output logic [31:0]           wb_we_onehot,
    output logic [31:0]           pending_mask
);
    import wb_port_arbiter_pkg::*;

    localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    wb_entry_t            buf_q [NUM_SRC];
    wb_entry_t            buf_d [NUM_SRC];
    logic [NUM_SRC-1:0]   buf_valid;
    logic [IW-1:0]        last_grant_q, last_grant_d;
    logic [NUM_SRC-1:0]   grant;
    logic                 gnt_any;
    logic [IW-1:0]        gnt_idx;
    wb_entry_t            gnt_entry;
    logic                 wr_en_c;
    int unsigned          cand;

    logic                 wb_we_q, wb_we_d;
    logic [AW-1:0]        wb_rd_q, wb_rd_d;
    logic [DW-1:0]        wb_data_q, wb_data_d;
    logic [31:0]          onehot_q, onehot_d;
    logic [31:0]          pend_dec [NUM_SRC];

    // Round-robin search starting one past the last granted source.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last_grant_q;
        grant   = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = (32'(last_grant_q) + k) % NUM_SRC;
            if (!gnt_any && buf_q[cand].valid) begin
                gnt_any     = 1'b1;
                gnt_idx     = IW'(cand);
                grant[cand] = 1'b1;
            end
        end
        gnt_entry    = buf_q[gnt_idx];
        last_grant_d = gnt_any ? gnt_idx : last_grant_q;
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            buf_valid[i] = buf_q[i].valid;
        end
    end

    assign src_ready = ~buf_valid | grant;

    // A new transfer overwrites the entry being granted, so back-to-back requests see no bubble.
    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            buf_d[i] = buf_q[i];
            if (src_valid[i] && src_ready[i]) begin
                buf_d[i].valid = 1'b1;
                buf_d[i].rd    = src_rd[i*AW +: AW];
                buf_d[i].data  = src_data[i*DW +: DW];
            end else if (grant[i]) begin
                buf_d[i].valid = 1'b0;
            end
        end
    end

    // Writes to r0 still consume their turn but never reach the register file.
    assign wr_en_c = gnt_any && (gnt_entry.rd != '0);

    always_comb begin
        wb_we_d   = wr_en_c;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (gnt_any) begin
            wb_rd_d   = gnt_entry.rd;
            wb_data_d = gnt_entry.data;
        end
    end

    wb_rd_decode #(.AW(AW)) u_wr_dec (
        .en_i     (wr_en_c),
        .addr_i   (gnt_entry.rd),
        .onehot_o (onehot_d)
    );

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_pend
        wb_rd_decode #(.AW(AW)) u_pend_dec (
            .en_i     (buf_q[g].valid && (buf_q[g].rd != '0)),
            .addr_i   (buf_q[g].rd),
            .onehot_o (pend_dec[g])
        );
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            pending_mask = pending_mask | pend_dec[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                buf_q[i] <= '0;
            end
            last_grant_q <= IW'(NUM_SRC - 1);
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            onehot_q     <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                buf_q[i] <= buf_d[i];
            end
            last_grant_q <= last_grant_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            onehot_q     <= onehot_d;
        end
    end

    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_we_onehot = onehot_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a per-source in-order write scoreboard.
module tb_wb_port_arbiter;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [NS-1:0]      src_valid;
    logic [NS*AW-1:0]   src_rd;
    logic [NS*DW-1:0]   src_data;
    logic [NS-1:0]      src_ready;
    logic               wb_we;
    logic [AW-1:0]      wb_rd;
    logic [DW-1:0]      wb_data;
    logic [31:0]        wb_we_onehot;
    logic [31:0]        pending_mask;

    wb_port_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .src_valid    (src_valid),
        .src_rd       (src_rd),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_we_onehot (wb_we_onehot),
        .pending_mask (pending_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned   src;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            checks = 0;
    int            fails  = 0;
    int            last_src = -1;
    bit            order_en = 1'b0;
    bit            sb_en = 1'b0;
    logic [NS-1:0] acc;
    logic [NS-1:0] rdy_s;
    int unsigned   seq [NS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] rd_of(input int unsigned s, input int unsigned q);
        int unsigned base;
        base = (s == 0) ? 1 : ((s == 1) ? 21 : 11);
        return AW'(base + (q % 8));
    endfunction

    task automatic set_src(input int unsigned s, input logic v, input logic [AW-1:0] rd,
                           input logic [DW-1:0] d);
        src_valid[s]          = v;
        src_rd[s*AW +: AW]    = rd;
        src_data[s*DW +: DW]  = d;
    endtask

    task automatic pop_check();
        int          idx;
        int unsigned s;
        idx = -1;
        s   = 32'(wb_data[31:28]);
        foreach (sbq[k]) begin
            if (idx < 0 && sbq[k].src == s) idx = k;
        end
        checks++;
        assert (idx >= 0) else begin
            fails++;
            $error("FAIL sb_unexpected: observed rd %0d data %h expected no write", wb_rd, wb_data);
        end
        if (idx >= 0) begin
            check("sb_rd", 32'(wb_rd), 32'(sbq[idx].rd));
            check("sb_data", wb_data, sbq[idx].data);
            sbq.delete(idx);
            if (order_en && last_src >= 0) check("rr_order", 32'(s), 32'((last_src + 1) % 3));
            last_src = int'(s);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then check registered outputs just after the edge.
    task automatic cycle();
        exp_t e;
        @(negedge clock);
        acc   = src_valid & src_ready;
        rdy_s = src_ready;
        if (sb_en) begin
            for (int s = 0; s < int'(NS); s++) begin
                if (acc[s] && src_rd[s*AW +: AW] != '0) begin
                    e.src  = 32'(s);
                    e.rd   = src_rd[s*AW +: AW];
                    e.data = src_data[s*DW +: DW];
                    sbq.push_back(e);
                end
            end
        end
        @(posedge clock);
        #1;
        if (sb_en && wb_we === 1'b1) pop_check();
        if (wb_we === 1'b1) check("onehot_we", wb_we_onehot, 32'(1) << wb_rd);
        else                check("onehot_idle", wb_we_onehot, 32'(0));
        check("pend_bit0", 32'(pending_mask[0]), 32'(0));
    endtask

    task automatic step_sat(input logic [NS-1:0] m);
        for (int s = 0; s < int'(NS); s++) begin
            if (m[s]) set_src(32'(s), 1'b1, rd_of(32'(s), seq[s]), {4'(s), 28'(seq[s])});
        end
        cycle();
        for (int s = 0; s < int'(NS); s++) begin
            if (m[s] && acc[s]) seq[s]++;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 12 && sbq.size() != 0; n++) cycle();
        check("drain_empty", 32'(sbq.size()), 32'(0));
    endtask

    initial begin
        int lat;
        bit done;
        reset_n   = 1'b0;
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;
        for (int s = 0; s < int'(NS); s++) seq[s] = 0;

        #2;
        check("rst_we", 32'(wb_we), 32'(0));
        check("rst_rd", 32'(wb_rd), 32'(0));
        check("rst_data", wb_data, 32'(0));
        check("rst_onehot", wb_we_onehot, 32'(0));
        check("rst_pend", pending_mask, 32'(0));
        check("rst_ready", 32'(src_ready), 32'(3'b111));
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single uncontended ALU write, two-cycle latency.
        set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        check("r30_acc", 32'(acc), 32'(3'b001));
        set_src(0, 1'b0, '0, '0);
        check("r30_we_c2", 32'(wb_we), 32'(0));
        check("r30_pend", pending_mask, 32'h0000_0020);
        cycle();
        check("r30_we", 32'(wb_we), 32'(1));
        check("r30_rd", 32'(wb_rd), 32'(5));
        check("r30_data", wb_data, 32'hDEADBEEF);
        check("r30_onehot", wb_we_onehot, 32'h0000_0020);
        check("r30_pend_clr", pending_mask, 32'(0));
        cycle();
        check("r21_we_idle", 32'(wb_we), 32'(0));
        check("r21_rd_hold", 32'(wb_rd), 32'(5));
        check("r21_data_hold", wb_data, 32'hDEADBEEF);

        // All three sources saturating.
        sb_en    = 1'b1;
        order_en = 1'b1;
        last_src = -1;
        for (int n = 0; n < 15; n++) begin
            step_sat(3'b111);
            if (n >= 1) begin
                check("r31_we", 32'(wb_we), 32'(1));
                check("r31_rdy1", 32'($countones(rdy_s)), 32'(1));
            end
        end
        for (int s = 0; s < int'(NS); s++) set_src(32'(s), 1'b0, '0, '0);
        drain();
        order_en = 1'b0;

        // Load to r0 is consumed silently.
        set_src(1, 1'b1, 5'd0, 32'h0000_1234);
        cycle();
        check("r32_acc", 32'(acc), 32'(3'b010));
        set_src(1, 1'b0, '0, '0);
        check("r32_pend", pending_mask, 32'(0));
        cycle();
        check("r32_we", 32'(wb_we), 32'(0));
        check("r32_onehot", wb_we_onehot, 32'(0));
        cycle();

        // Multdiv to r12 under ALU+load saturation.
        for (int n = 0; n < 6; n++) step_sat(3'b011);
        set_src(2, 1'b1, 5'd12, {4'd2, 28'h000_0012});
        done = 1'b0;
        for (int n = 0; n < 4 && !done; n++) begin
            step_sat(3'b011);
            done = acc[2];
        end
        check("r33_acc", 32'(done), 32'(1));
        set_src(2, 1'b0, '0, '0);
        check("r33_pend_set", 32'(pending_mask[12]), 32'(1));
        done = 1'b0;
        lat  = 0;
        for (int n = 0; n < 5 && !done; n++) begin
            step_sat(3'b011);
            lat++;
            if (wb_we === 1'b1 && wb_rd == 5'd12) done = 1'b1;
            else check("r33_pend_hold", 32'(pending_mask[12]), 32'(1));
        end
        check("r33_written", 32'(done), 32'(1));
        check("r33_latency", 32'(lat <= 3), 32'(1));
        check("r33_pend_clr", 32'(pending_mask[12]), 32'(0));
        for (int s = 0; s < int'(NS); s++) set_src(32'(s), 1'b0, '0, '0);
        drain();

        // Asynchronous reset with all buffers full.
        for (int n = 0; n < 3; n++) step_sat(3'b111);
        #1;
        reset_n = 1'b0;
        #1;
        check("r34_pend", pending_mask, 32'(0));
        check("r34_we", 32'(wb_we), 32'(0));
        check("r34_ready", 32'(src_ready), 32'(3'b111));
        check("r34_onehot", wb_we_onehot, 32'(0));
        check("r34_rd", 32'(wb_rd), 32'(0));
        check("r34_data", wb_data, 32'(0));
        sbq.delete();
        for (int s = 0; s < int'(NS); s++) set_src(32'(s), 1'b0, '0, '0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            check("r34_nostale", 32'(wb_we), 32'(0));
        end

        // After reset source 0 has first priority.
        order_en = 1'b1;
        last_src = 2;
        step_sat(3'b111);
        check("r27_acc", 32'(acc), 32'(3'b111));
        for (int s = 0; s < int'(NS); s++) set_src(32'(s), 1'b0, '0, '0);
        drain();
        order_en = 1'b0;

        check("sb_final", 32'(sbq.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
